// File: rtl/regbank_arbiter_if.sv
// Bus bundle between the two register-bank requesters, the arbiter and the bank.
// The slave modport is the arbiter's view; master is the requester/bank side.
interface regbank_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;

    logic              bank_wr;
    logic [ADDR_W-1:0] bank_addr;
    logic [DATA_W-1:0] bank_wdata;
    logic [DATA_W-1:0] bank_rdata;

    logic              busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_rdata,
        output bank_wr, bank_addr, bank_wdata,
        input  bank_rdata,
        output busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_rdata,
        input  bank_wr, bank_addr, bank_wdata,
        output bank_rdata,
        input  busy
    );
endinterface

// File: rtl/regbank_arbiter.sv
// Two-requester arbiter (host m0, SPI engine m1) for the single-port register bank.
// Round-robin by default; define REGBANK_ARB_FIXED_PRIO_EN for fixed m0 priority.
module regbank_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    regbank_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    state_e            state_q,      state_d;
    logic              grant_q,      grant_d;
`ifndef REGBANK_ARB_FIXED_PRIO_EN
    logic              last_grant_q, last_grant_d;
`endif
    logic              bank_wr_q,    bank_wr_d;
    logic [ADDR_W-1:0] bank_addr_q,  bank_addr_d;
    logic [DATA_W-1:0] bank_wdata_q, bank_wdata_d;
    logic              m0_ack_q,     m0_ack_d;
    logic              m1_ack_q,     m1_ack_d;
    logic [DATA_W-1:0] m0_rdata_q,   m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q,   m1_rdata_d;
    logic              busy_q,       busy_d;
    logic              pick_m1_s;

    // Arbitration decision among the currently requesting masters.
    always_comb begin
        pick_m1_s = 1'b0;
        if (bus.m0_req && bus.m1_req) begin
`ifdef REGBANK_ARB_FIXED_PRIO_EN
            pick_m1_s = 1'b0;
`else
            pick_m1_s = ~last_grant_q;
`endif
        end else if (bus.m1_req) begin
            pick_m1_s = 1'b1;
        end else begin
            pick_m1_s = 1'b0;
        end
    end

    // Next-state and next-output logic; the bank_* registers double as the latched request.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
`ifndef REGBANK_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        bank_wr_d    = 1'b0;
        bank_addr_d  = {ADDR_W{1'b0}};
        bank_wdata_d = {DATA_W{1'b0}};
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;
        m0_rdata_d   = {DATA_W{1'b0}};
        m1_rdata_d   = {DATA_W{1'b0}};

        case (state_q)
            ST_IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    grant_d = pick_m1_s;
                    state_d = ST_ACCESS;
                    if (pick_m1_s) begin
                        bank_wr_d    = bus.m1_we;
                        bank_addr_d  = bus.m1_addr;
                        bank_wdata_d = bus.m1_wdata;
                    end else begin
                        bank_wr_d    = bus.m0_we;
                        bank_addr_d  = bus.m0_addr;
                        bank_wdata_d = bus.m0_wdata;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                state_d = ST_DONE;
                if (grant_q) begin
                    m1_ack_d   = 1'b1;
                    m1_rdata_d = bus.bank_rdata;
                end else begin
                    m0_ack_d   = 1'b1;
                    m0_rdata_d = bus.bank_rdata;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
`ifndef REGBANK_ARB_FIXED_PRIO_EN
                last_grant_d = grant_q;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; async reset also kills an in-flight bank strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
`ifndef REGBANK_ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
            bank_wr_q    <= 1'b0;
            bank_addr_q  <= {ADDR_W{1'b0}};
            bank_wdata_q <= {DATA_W{1'b0}};
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_rdata_q   <= {DATA_W{1'b0}};
            m1_rdata_q   <= {DATA_W{1'b0}};
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
`ifndef REGBANK_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
            bank_wr_q    <= bank_wr_d;
            bank_addr_q  <= bank_addr_d;
            bank_wdata_q <= bank_wdata_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.bank_wr    = bank_wr_q;
    assign bus.bank_addr  = bank_addr_q;
    assign bus.bank_wdata = bank_wdata_q;
    assign bus.m0_ack     = m0_ack_q;
    assign bus.m1_ack     = m1_ack_q;
    assign bus.m0_rdata   = m0_rdata_q;
    assign bus.m1_rdata   = m1_rdata_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_regbank_arbiter.sv
// Directed bench for regbank_arbiter with a 16-entry behavioural register bank.
// Expectations are hand-derived; REGBANK_ARB_FIXED_PRIO_EN selects the fixed-priority ones.
module tb_regbank_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regbank_arbiter_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    regbank_arbiter #(.ADDR_W(4), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register bank: reset fills entry i with nibble i repeated.
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= {8{i[3:0]}};
        end else if (bus.bank_wr) begin
            mem[bus.bank_addr] <= bus.bank_wdata;
        end
    end
    assign bus.bank_rdata = mem[bus.bank_addr];

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic e0, e1;
        rst          = 1'b1;
        bus.m0_req   = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = 4'd0; bus.m0_wdata = 32'd0;
        bus.m1_req   = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = 4'd0; bus.m1_wdata = 32'd0;
        step(); step();
        check_eq("rst_busy",   {31'd0, bus.busy},    32'd0);
        check_eq("rst_wr",     {31'd0, bus.bank_wr}, 32'd0);
        check_eq("rst_ack0",   {31'd0, bus.m0_ack},  32'd0);
        check_eq("rst_ack1",   {31'd0, bus.m1_ack},  32'd0);
        check_eq("rst_addr",   {28'd0, bus.bank_addr}, 32'd0);
        rst = 1'b0;
        step();
        check_eq("idle_busy",  {31'd0, bus.busy},    32'd0);

        // m0 write addr 3
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 4'd3; bus.m0_wdata = 32'hDEADBEEF;
        step();
        check_eq("w_wr",       {31'd0, bus.bank_wr},   32'd1);
        check_eq("w_addr",     {28'd0, bus.bank_addr}, 32'd3);
        check_eq("w_wdata",    bus.bank_wdata,         32'hDEADBEEF);
        check_eq("w_busy",     {31'd0, bus.busy},      32'd1);
        check_eq("w_noack",    {31'd0, bus.m0_ack},    32'd0);
        step();
        check_eq("w_wr_off",   {31'd0, bus.bank_wr},   32'd0);
        check_eq("w_ack0",     {31'd0, bus.m0_ack},    32'd1);
        check_eq("w_ack1",     {31'd0, bus.m1_ack},    32'd0);
        bus.m0_req = 1'b0;
        step();
        check_eq("w_ack_end",  {31'd0, bus.m0_ack},    32'd0);
        check_eq("w_idle",     {31'd0, bus.busy},      32'd0);

        // m0 read addr 3; wdata is driven but must not strobe the bank
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 4'd3; bus.m0_wdata = 32'hCAFEF00D;
        step();
        check_eq("r_wr",       {31'd0, bus.bank_wr},   32'd0);
        check_eq("r_addr",     {28'd0, bus.bank_addr}, 32'd3);
        check_eq("r_wdata",    bus.bank_wdata,         32'hCAFEF00D);
        step();
        check_eq("r_ack0",     {31'd0, bus.m0_ack},    32'd1);
        check_eq("r_rdata0",   bus.m0_rdata,           32'hDEADBEEF);
        check_eq("r_rdata1",   bus.m1_rdata,           32'd0);
        bus.m0_req = 1'b0;
        step();

        // reset while an m0 write is in ACCESS
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 4'd5; bus.m0_wdata = 32'hA5A5A5A5;
        step();
        check_eq("ra_wr_pre",  {31'd0, bus.bank_wr},   32'd1);
        rst = 1'b1;
        #1;
        check_eq("ra_wr_drop", {31'd0, bus.bank_wr},   32'd0);
        check_eq("ra_busy",    {31'd0, bus.busy},      32'd0);
        check_eq("ra_addr",    {28'd0, bus.bank_addr}, 32'd0);
        bus.m0_req = 1'b0;
        step();
        check_eq("ra_noack",   {31'd0, bus.m0_ack},    32'd0);
        rst = 1'b0;
        step();
        check_eq("ra_noack2",  {31'd0, bus.m0_ack},    32'd0);
        check_eq("ra_idle",    {31'd0, bus.busy},      32'd0);

        // both requesters held high after reset
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 4'd1;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 4'd2;
        for (int c = 1; c <= 12; c++) begin
            step();
`ifdef REGBANK_ARB_FIXED_PRIO_EN
            e0 = (c % 3 == 2);
            e1 = 1'b0;
`else
            e0 = (c % 3 == 2) && ((c / 3) % 2 == 0);
            e1 = (c % 3 == 2) && ((c / 3) % 2 == 1);
`endif
            check_eq($sformatf("rr_ack0_c%0d", c), {31'd0, bus.m0_ack}, {31'd0, e0});
            check_eq($sformatf("rr_ack1_c%0d", c), {31'd0, bus.m1_ack}, {31'd0, e1});
            if (e0) check_eq($sformatf("rr_rd0_c%0d", c), bus.m0_rdata, 32'h11111111);
            if (e1) check_eq($sformatf("rr_rd1_c%0d", c), bus.m1_rdata, 32'h22222222);
        end
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        step();
        check_eq("rr_idle",    {31'd0, bus.busy},      32'd0);

        // m1 write addr 15, inputs changed during ACCESS
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 4'd15; bus.m1_wdata = 32'h12345678;
        step();
        bus.m1_addr = 4'd7; bus.m1_wdata = 32'hFFFFFFFF;
        #1;
        check_eq("fl_addr",    {28'd0, bus.bank_addr}, 32'd15);
        check_eq("fl_wdata",   bus.bank_wdata,         32'h12345678);
        check_eq("fl_wr",      {31'd0, bus.bank_wr},   32'd1);
        step();
        check_eq("fl_ack1",    {31'd0, bus.m1_ack},    32'd1);
        check_eq("fl_ack0",    {31'd0, bus.m0_ack},    32'd0);
        check_eq("fl_mem15",   mem[15],                32'h12345678);
        check_eq("fl_mem7",    mem[7],                 32'h77777777);
        bus.m1_req = 1'b0;
        step();

        // m0 read addr 15, req dropped right after the grant
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 4'd15;
        step();
        bus.m0_req = 1'b0;
        step();
        check_eq("ed_ack",     {31'd0, bus.m0_ack},    32'd1);
        check_eq("ed_rdata",   bus.m0_rdata,           32'h12345678);
        step();
        check_eq("ed_ack_end", {31'd0, bus.m0_ack},    32'd0);
        check_eq("ed_busy",    {31'd0, bus.busy},      32'd0);
        step(); step();
        check_eq("ed_no2nd",   {31'd0, bus.busy},      32'd0);
        check_eq("ed_noack",   {31'd0, bus.m0_ack},    32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
